// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, state encoding and control-word layout for the micro-sequencer
package control_unit_pkg;
  localparam logic [3:0] OPR_ADD = 4'b1000;
  localparam logic [3:0] OPR_SUB = 4'b1001;
  localparam logic [3:0] OPR_LD  = 4'b1010;
  localparam logic [3:0] OPR_XCH = 4'b1011;
  localparam logic [3:0] OPR_BBL = 4'b1100;
  localparam logic [3:0] OPR_LDM = 4'b1101;
  localparam logic [1:0] PATH_IDLE = 2'b00;
  localparam logic [1:0] PATH_IN   = 2'b01;
  localparam logic [1:0] PATH_OUT  = 2'b10;
  localparam logic [1:0] ACC_HOLD = 2'b00;
  localparam logic [1:0] ACC_ALU  = 2'b01;
  localparam logic [1:0] ACC_BUS  = 2'b10;
  localparam logic [1:0] ACC_DRV  = 2'b11;
  localparam logic [1:0] IO_IDLE = 2'b00;
  localparam logic [1:0] IO_DRV  = 2'b01;
  localparam logic [1:0] IO_TAKE = 2'b10;
  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EX1    = 3'd3,
    S_EX2    = 3'd4,
    S_EX3    = 3'd5
  } state_t;
  typedef struct packed {
    logic       buf_en;
    logic [1:0] buf_path;
    logic       alu_en;
    logic       alu_op;
    logic       temp_en;
    logic [1:0] acc_en;
    logic [1:0] ir_io;
    logic       ir_we;
    logic       instr_we;
    logic [3:0] sel;
    logic [3:0] bus;
  } ctrl_t;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction in, datapath enables/selects out
interface control_unit_if;
  logic [7:0] instruction;
  logic       data_bus_buffer_enable;
  logic [1:0] data_bus_buffer_path;
  logic       ALU_enable;
  logic       ALU_operation;
  logic       temp_register_enable;
  logic [1:0] accumulator_enable;
  logic [1:0] index_register_IO;
  logic       index_register_I_WE;
  logic       instruction_register_WE;
  logic [3:0] index_register_select;
  logic [3:0] data_bus;
  modport master (
    input  instruction,
    output data_bus_buffer_enable, data_bus_buffer_path, ALU_enable, ALU_operation,
           temp_register_enable, accumulator_enable, index_register_IO, index_register_I_WE,
           instruction_register_WE, index_register_select, data_bus
  );
  modport slave (
    output instruction,
    input  data_bus_buffer_enable, data_bus_buffer_path, ALU_enable, ALU_operation,
           temp_register_enable, accumulator_enable, index_register_IO, index_register_I_WE,
           instruction_register_WE, index_register_select, data_bus
  );
endinterface

// File: rtl/control_unit_decode.sv
// control_unit_decode: pure combinational (state, opcode) -> control word
module control_unit_decode
  import control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [7:0] opcode,
  output ctrl_t      ctrl
);
  logic [3:0] opr;
  logic [3:0] opa;
  assign opr = opcode[7:4];
  assign opa = opcode[3:0];
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.instr_we = 1'b1;
        ctrl.buf_en   = 1'b1;
        ctrl.buf_path = PATH_IN;
      end
      S_EX1: case (opr)
        OPR_ADD, OPR_SUB, OPR_XCH: begin
          ctrl.ir_io   = IO_DRV;
          ctrl.sel     = opa;
          ctrl.temp_en = 1'b1;
        end
        OPR_LD: begin
          ctrl.ir_io  = IO_DRV;
          ctrl.sel    = opa;
          ctrl.acc_en = ACC_BUS;
        end
        OPR_LDM, OPR_BBL: begin
          ctrl.bus    = opa;
          ctrl.acc_en = ACC_BUS;
        end
        default: ;
      endcase
      S_EX2: case (opr)
        OPR_ADD, OPR_SUB: begin
          ctrl.alu_en = 1'b1;
          ctrl.alu_op = opr == OPR_SUB;
          ctrl.acc_en = ACC_ALU;
        end
        OPR_XCH: begin
          ctrl.acc_en = ACC_DRV;
          ctrl.ir_io  = IO_TAKE;
          ctrl.ir_we  = 1'b1;
          ctrl.sel    = opa;
        end
        default: ;
      endcase
      // XCH finishes by passing the old register value from temp into the accumulator
      S_EX3: ctrl.acc_en = opr == OPR_XCH ? ACC_ALU : ACC_HOLD;
      default: ;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: five-state micro-sequencer with registered datapath controls
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clk_2,
  input  logic           reset,
  control_unit_if.master cu
);
  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  ctrl_t      ctrl_q, ctrl_d;
  always_comb begin
    state_d  = state_q == S_EX3 ? S_FETCH : state_t'(state_q + 3'd1);
    opcode_d = state_q == S_FETCH ? cu.instruction : opcode_q;
  end
  control_unit_decode u_decode (
    .state  (state_d),
    .opcode (opcode_q),
    .ctrl   (ctrl_d)
  );
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q  <= S_RST;
      opcode_q <= 8'h00;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ctrl_q   <= ctrl_d;
    end
  end
  assign cu.data_bus_buffer_enable  = ctrl_q.buf_en;
  assign cu.data_bus_buffer_path    = ctrl_q.buf_path;
  assign cu.ALU_enable              = ctrl_q.alu_en;
  assign cu.ALU_operation           = ctrl_q.alu_op;
  assign cu.temp_register_enable    = ctrl_q.temp_en;
  assign cu.accumulator_enable      = ctrl_q.acc_en;
  assign cu.index_register_IO       = ctrl_q.ir_io;
  assign cu.index_register_I_WE     = ctrl_q.ir_we;
  assign cu.instruction_register_WE = ctrl_q.instr_we;
  assign cu.index_register_select   = ctrl_q.sel;
  assign cu.data_bus                = ctrl_q.bus;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random and directed stimulus checked against a phase/opcode reference model
module tb_control_unit;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int phase = -1;
  logic [7:0] op_m = 8'h00;
  logic [19:0] obs [5];
  logic [19:0] dut_vec;
  control_unit_if bus_if ();
  control_unit dut (
    .clk_2 (clk_2),
    .reset (reset),
    .cu    (bus_if)
  );
  always #5 clk_2 = ~clk_2;
  assign dut_vec = {bus_if.data_bus_buffer_enable, bus_if.data_bus_buffer_path, bus_if.ALU_enable,
                    bus_if.ALU_operation, bus_if.temp_register_enable, bus_if.accumulator_enable,
                    bus_if.index_register_IO, bus_if.index_register_I_WE, bus_if.instruction_register_WE,
                    bus_if.index_register_select, bus_if.data_bus};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t phase=%0d op=%h)", tag, got, exp, $time, phase, op_m);
    end
  endtask
  // phase: -1 in reset, 0 FETCH, 1 DECODE, 2..4 EX1..EX3
  function automatic logic [19:0] model(input int ph, input logic [7:0] op);
    logic [3:0] r = op[7:4];
    logic [3:0] a = op[3:0];
    logic arith = r == 4'h8 || r == 4'h9;
    logic reg_rd = r >= 4'h8 && r <= 4'hB;
    logic imm = r == 4'hC || r == 4'hD;
    logic       be = ph == 0;
    logic [1:0] path = ph == 0 ? 2'b01 : 2'b00;
    logic       aen = ph == 3 && arith;
    logic       aop = ph == 3 && r == 4'h9;
    logic       tmp = ph == 2 && (arith || r == 4'hB);
    logic [1:0] acc = (ph == 2 && (r == 4'hA || imm)) ? 2'b10 :
                      (ph == 3 && arith) ? 2'b01 :
                      (ph == 3 && r == 4'hB) ? 2'b11 :
                      (ph == 4 && r == 4'hB) ? 2'b01 : 2'b00;
    logic [1:0] io = (ph == 2 && reg_rd) ? 2'b01 : (ph == 3 && r == 4'hB) ? 2'b10 : 2'b00;
    logic       we = ph == 3 && r == 4'hB;
    logic       irwe = ph == 0;
    logic [3:0] sel = io != 2'b00 ? a : 4'h0;
    logic [3:0] db = (ph == 2 && imm) ? a : 4'h0;
    return {be, path, aen, aop, tmp, acc, io, we, irwe, sel, db};
  endfunction
  task automatic step(input logic rst, input logic [7:0] instr);
    int prev;
    @(negedge clk_2);
    reset = rst;
    bus_if.instruction = instr;
    @(posedge clk_2);
    prev = phase;
    if (rst) begin
      phase = -1;
      op_m = 8'h00;
    end else begin
      if (prev == 0) op_m = instr;
      phase = prev == -1 ? 0 : (prev + 1) % 5;
    end
    #1;
    chk("ctrl_word", {12'h0, dut_vec}, {12'h0, model(phase, op_m)});
    if (phase >= 0) obs[phase] = dut_vec;
  endtask
  task automatic run(input logic [7:0] op);
    step(1'b0, op);
    for (int i = 0; i < 4; i++) step(1'b0, 8'($urandom));
  endtask
  initial begin
    bus_if.instruction = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom));
      chk("rst_zero", {12'h0, dut_vec}, 32'h0);
    end
    step(1'b0, 8'($urandom));
    chk("fetch_irwe", {31'h0, bus_if.instruction_register_WE}, 32'h1);
    chk("fetch_path", {30'h0, bus_if.data_bus_buffer_path}, 32'h1);
    run(8'h85);
    chk("add_ex1_sel", {28'h0, obs[2][7:4]}, 32'h5);
    chk("add_ex1_io", {30'h0, obs[2][11:10]}, 32'h1);
    chk("add_ex1_tmp", {31'h0, obs[2][14]}, 32'h1);
    chk("add_ex2_aen", {31'h0, obs[3][16]}, 32'h1);
    chk("add_ex2_acc", {30'h0, obs[3][13:12]}, 32'h1);
    run(8'h93);
    chk("sub_ex2_op", {31'h0, obs[3][15]}, 32'h1);
    run(8'hBA);
    chk("xch_ex2_acc", {30'h0, obs[3][13:12]}, 32'h3);
    chk("xch_ex2_io", {30'h0, obs[3][11:10]}, 32'h2);
    chk("xch_ex2_we", {31'h0, obs[3][9]}, 32'h1);
    chk("xch_ex2_sel", {28'h0, obs[3][7:4]}, 32'hA);
    chk("xch_ex3_acc", {30'h0, obs[4][13:12]}, 32'h1);
    run(8'hD7);
    chk("ldm_ex1_bus", {28'h0, obs[2][3:0]}, 32'h7);
    chk("ldm_ex1_acc", {30'h0, obs[2][13:12]}, 32'h2);
    run(8'hC7);
    chk("bbl_ex1_bus", {28'h0, obs[2][3:0]}, 32'h7);
    chk("bbl_ex1_acc", {30'h0, obs[2][13:12]}, 32'h2);
    run(8'h00);
    chk("nop_ex1", {12'h0, obs[2]}, 32'h0);
    step(1'b0, 8'h85);
    step(1'b0, 8'($urandom));
    step(1'b0, 8'($urandom));
    chk("abort_pre_aen", {31'h0, bus_if.ALU_enable}, 32'h1);
    step(1'b1, 8'($urandom));
    chk("abort_zero", {12'h0, dut_vec}, 32'h0);
    step(1'b0, 8'($urandom));
    chk("abort_fetch", {31'h0, bus_if.instruction_register_WE}, 32'h1);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ins = 8'($urandom);
      if ($urandom_range(0, 2) == 0) ins[7:4] = 4'($urandom_range(8, 13));
      step($urandom_range(0, 49) == 0, ins);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
